// File: rtl/dsng_rot_lfsr_uni_if.sv
// dsng_rot_lfsr_uni_if: operand-in / bit-pair-out bundle for the two-channel stochastic number generator
//   iA, iB       operand pair (unsigned, DATAWD bits), qualified by in_valid / in_ready
//   flush        synchronous abort back to IDLE
//   oBitA, oBitB stochastic bit pair with frame_start / frame_last, qualified by out_valid / out_ready
//   master = operand source / bitstream sink, slave = generator
interface dsng_rot_lfsr_uni_if #(parameter int DATAWD = 8);
    logic [DATAWD-1:0] iA;
    logic [DATAWD-1:0] iB;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              oBitA;
    logic              oBitB;
    logic              out_valid;
    logic              out_ready;
    logic              frame_start;
    logic              frame_last;
    modport master (
        output iA, iB, in_valid, flush, out_ready,
        input  in_ready, oBitA, oBitB, out_valid, frame_start, frame_last
    );
    modport slave (
        input  iA, iB, in_valid, flush, out_ready,
        output in_ready, oBitA, oBitB, out_valid, frame_start, frame_last
    );
endinterface

// File: rtl/dsng_rot_lfsr_uni.sv
// dsng_rot_lfsr_uni: two-channel binary-to-unary stochastic bitstream encoder driven by one 8-bit LFSR
//   clk    clock
//   rst_n  asynchronous reset, active low
//   bus    slave side of dsng_rot_lfsr_uni_if: accepts one operand pair, then streams a
//          255-beat frame whose ones-count per channel equals that channel's operand
module dsng_rot_lfsr_uni #(
    parameter int DATAWD    = 8,
    parameter int FRAME_LEN = 255
) (
    input logic               clk,
    input logic               rst_n,
    dsng_rot_lfsr_uni_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [DATAWD-1:0] LAST_BEAT = DATAWD'(FRAME_LEN - 1);
    state_t            state, state_nxt;
    logic [DATAWD-1:0] lfsr, lfsr_rev, beat, buf_a, buf_b;
    logic              fb, accept, xfer, run;
    // XNOR feedback makes all-ones the lock-up state, so 00 is a legal seed and FF is never visited
    assign fb     = ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]);
    assign accept = (state == IDLE) && bus.in_valid;
    assign xfer   = (state == RUN) && bus.out_ready;
    // channel B sees the LFSR bit-reversed, which decorrelates it from channel A
    for (genvar i = 0; i < DATAWD; i++) begin : g_rev
        assign lfsr_rev[i] = lfsr[DATAWD-1-i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = bus.flush                      ? IDLE :
                    accept                         ? RUN  :
                    (xfer && beat == LAST_BEAT)    ? IDLE : state;
    end
    always_comb begin
        run             = (state == RUN);
        bus.in_ready    = !run;
        bus.out_valid   = run;
        bus.oBitA       = run && (buf_a > lfsr);
        bus.oBitB       = run && (buf_b > lfsr_rev);
        bus.frame_start = run && (beat == '0);
        bus.frame_last  = run && (beat == LAST_BEAT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= '0;
            beat  <= '0;
            buf_a <= '0;
            buf_b <= '0;
        end else if (bus.flush) begin
            lfsr <= '0;
            beat <= '0;
        end else if (accept) begin
            buf_a <= bus.iA;
            buf_b <= bus.iB;
            lfsr  <= '0;
            beat  <= '0;
        end else if (xfer) begin
            lfsr <= {lfsr[DATAWD-2:0], fb};
            beat <= beat + 1'b1;
        end
    end
endmodule

// File: tb/tb_dsng_rot_lfsr_uni.sv
// tb_dsng_rot_lfsr_uni: directed scenario bench for the two-channel stochastic number generator
module tb_dsng_rot_lfsr_uni;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    dsng_rot_lfsr_uni_if bus ();
    dsng_rot_lfsr_uni dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [7:0] lnext(input logic [7:0] l);
        return {l[6:0], ~(l[7] ^ l[5] ^ l[4] ^ l[3])};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // {out_valid, in_ready, oBitA, oBitB, frame_start, frame_last}
    function automatic logic [5:0] obs();
        return {bus.out_valid, bus.in_ready, bus.oBitA, bus.oBitB, bus.frame_start, bus.frame_last};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        bus.iA = a;
        bus.iB = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=%b required 1 within 300 cycles", bus.in_ready);
        end
        tick;
        bus.in_valid = 1'b0;
    endtask

    // Streams beats 0..stop_at-1 of the current frame, checking every presented beat.
    task automatic stream(input logic [7:0] a, input logic [7:0] b, input bit stall, input int stop_at,
                          output int ones_a, output int ones_b, output int both,
                          output logic [254:0] ra, output logic [254:0] rb);
        logic [7:0] l;
        logic [5:0] exp;
        bit         hold;
        l = 8'h00;
        ones_a = 0;
        ones_b = 0;
        both = 0;
        ra = '0;
        rb = '0;
        for (int k = 0; k < stop_at; k++) begin
            exp = {1'b1, 1'b0, a > l, b > rev8(l), k == 0, k == 254};
            do begin
                hold = stall && ($urandom_range(0, 2) == 0);
                vectors++;
                if (obs() !== exp) begin
                    errors++;
                    $display("FAIL beat %0d: outputs=%b required %b (a=%0d b=%0d)", k, obs(), exp, a, b);
                end
                bus.out_ready = !hold;
                if (!hold) begin
                    ones_a += int'(bus.oBitA);
                    ones_b += int'(bus.oBitB);
                    both   += int'(bus.oBitA & bus.oBitB);
                    ra[k] = bus.oBitA;
                    rb[k] = bus.oBitB;
                end
                tick;
            end while (hold);
            l = lnext(l);
        end
        bus.out_ready = 1'b1;
        if (stop_at == 255) begin
            vectors++;
            if (obs() !== 6'b010000) begin
                errors++;
                $display("FAIL frame_end: outputs=%b required 010000", obs());
            end
        end
    endtask

    task automatic check_totals(input string name, input int oa, input int ob, input int a, input int b);
        vectors++;
        if (oa !== a || ob !== b) begin
            errors++;
            $display("FAIL %s totals: got %0d/%0d required %0d/%0d", name, oa, ob, a, b);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if (obs() !== 6'b010000) begin
            errors++;
            $display("FAIL reset: outputs=%b required 010000", obs());
        end
        tick;
        rst_n = 1'b1;
        tick;
        vectors++;
        if (obs() !== 6'b010000) begin
            errors++;
            $display("FAIL post_reset_idle: outputs=%b required 010000", obs());
        end
    endtask

    task automatic test_extremes;
        int oa, ob, bo;
        logic [254:0] ra, rb;
        send(8'd0, 8'd255);
        stream(8'd0, 8'd255, 1'b0, 255, oa, ob, bo, ra, rb);
        check_totals("extremes", oa, ob, 0, 255);
    endtask

    task automatic test_small;
        int oa, ob, bo;
        logic [254:0] ra, rb;
        send(8'd2, 8'd1);
        stream(8'd2, 8'd1, 1'b0, 255, oa, ob, bo, ra, rb);
        check_totals("small", oa, ob, 2, 1);
        vectors++;
        if (ra !== 255'b11 || rb !== 255'b1) begin
            errors++;
            $display("FAIL small_positions: A=%h B=%h required A=3 B=1", ra, rb);
        end
    endtask

    task automatic test_stall;
        int oa, ob, bo;
        logic [254:0] ra, rb;
        send(8'd128, 8'd77);
        stream(8'd128, 8'd77, 1'b1, 255, oa, ob, bo, ra, rb);
        check_totals("stall", oa, ob, 128, 77);
    endtask

    task automatic test_random;
        int oa, ob, bo, err;
        logic [7:0] a, b;
        logic [254:0] ra, rb;
        for (int f = 0; f < 200; f++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            send(a, b);
            stream(a, b, 1'b0, 255, oa, ob, bo, ra, rb);
            check_totals("random", oa, ob, int'(a), int'(b));
            err = bo * 255 - int'(a) * int'(b);
            if (err < 0) err = -err;
            vectors++;
            if (err > 12 * 255) begin
                errors++;
                $display("FAIL decorrelation: both=%0d a=%0d b=%0d scaled error %0d exceeds %0d", bo, a, b, err, 12 * 255);
            end
        end
    endtask

    task automatic test_flush;
        int oa, ob, bo;
        logic [254:0] ra, rb;
        send(8'd50, 8'd60);
        stream(8'd50, 8'd60, 1'b0, 100, oa, ob, bo, ra, rb);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        bus.flush = 1'b0;
        vectors++;
        if (obs() !== 6'b010000) begin
            errors++;
            $display("FAIL flush_idle: outputs=%b required 010000", obs());
        end
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.iA = 8'd99;
        bus.iB = 8'd99;
        tick;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (obs() !== 6'b010000) begin
            errors++;
            $display("FAIL flush_priority: outputs=%b required 010000", obs());
        end
        send(8'd10, 8'd20);
        stream(8'd10, 8'd20, 1'b0, 255, oa, ob, bo, ra, rb);
        check_totals("after_flush", oa, ob, 10, 20);
    endtask

    task automatic test_reset_mid;
        int oa, ob, bo;
        logic [254:0] ra, rb;
        send(8'd200, 8'd100);
        bus.in_valid = 1'b1;
        bus.iA = 8'd3;
        bus.iB = 8'd4;
        stream(8'd200, 8'd100, 1'b0, 50, oa, ob, bo, ra, rb);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== 6'b010000) begin
            errors++;
            $display("FAIL reset_mid: outputs=%b required 010000", obs());
        end
        bus.in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        vectors++;
        if (obs() !== 6'b010000) begin
            errors++;
            $display("FAIL reset_mid_idle: outputs=%b required 010000", obs());
        end
        send(8'd40, 8'd41);
        stream(8'd40, 8'd41, 1'b0, 255, oa, ob, bo, ra, rb);
        check_totals("after_reset", oa, ob, 40, 41);
    endtask

    initial begin
        bus.iA = '0;
        bus.iB = '0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        test_reset;
        test_extremes;
        test_small;
        test_stall;
        test_flush;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
